pmc_shift_sequencer: RTL and testbench

//  Sequences one serial shift of the pixel-matrix shift chain for the PMC peripheral.
//  - Drives pm_din and generates a programmable number of pm_clk_sh pulses.
//  - After each pulse, captures {pm_dout_b, pm_dout_a} into a small readout FIFO drained by the PMC register logic.
//  - Sits between the PMC data-bus registers and the pm_ctrl / pm_data pins of the SoC.

---
 rtl/pmc_shift_sequencer.sv | 143 ++++++++++++++
 tb/tb_pmc_shift_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pmc_shift_sequencer.sv
// Serial shift sequencer for the PMC pixel-matrix chain: drives pm_din, pulses pm_clk_sh
// and captures both matrix outputs into a readout FIFO. Optional macro: PMC_SEQ_STALL_STATS_EN.
module pmc_shift_sequencer #(
  parameter int CNT_W      = 16,
  parameter int DIV_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_bit_count,
  input  logic [DIV_W-1:0] i_clk_div,
  input  logic [31:0]      i_din_word,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_pm_clk_sh,
  output logic [31:0]      o_pm_din,
  input  logic [31:0]      i_pm_dout_a,
  input  logic [31:0]      i_pm_dout_b,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [63:0]      o_rd_data,
  output logic [15:0]      o_stall_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_rem;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_div_cnt;
  logic [31:0]      r_pm_din;
  logic [63:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;

  logic w_empty, w_full, w_pop, w_cap, w_push, w_stall, w_start_acc;

  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop       = !w_empty && i_rd_ready;
  // Capture point is the last LOW cycle; a same-cycle pop frees the slot even when full.
  assign w_cap       = (r_state == S_LOW) && (r_div_cnt == '0) && !i_abort;
  assign w_push      = w_cap && (!w_full || w_pop);
  assign w_stall     = w_cap && !w_push;
  assign w_start_acc = (r_state == S_IDLE) && i_start;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_div     <= '0;
      r_div_cnt <= '0;
      r_pm_din  <= '0;
    end else if (i_abort && r_state != S_IDLE) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          if (i_bit_count != '0) begin
            r_state  <= S_SETUP;
            r_rem    <= i_bit_count;
            r_div    <= i_clk_div;
            r_pm_din <= i_din_word;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_SETUP: begin
          r_state   <= S_HIGH;
          r_div_cnt <= r_div;
        end
        S_HIGH: begin
          if (r_div_cnt == '0) begin
            r_state   <= S_LOW;
            r_div_cnt <= r_div;
          end else begin
            r_div_cnt <= r_div_cnt - DIV_W'(1);
          end
        end
        S_LOW: begin
          if (r_div_cnt != '0) begin
            r_div_cnt <= r_div_cnt - DIV_W'(1);
          end else if (w_push) begin
            r_rem <= r_rem - CNT_W'(1);
            if (r_rem == CNT_W'(1)) begin
              r_state <= S_DONE;
            end else begin
              r_state   <= S_HIGH;
              r_div_cnt <= r_div;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= {i_pm_dout_b, i_pm_dout_a};
        r_wptr                <= r_wptr + PTR_ONE;
      end
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
    end
  end

`ifdef PMC_SEQ_STALL_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                                r_stall_cnt <= '0;
    else if (w_start_acc)                        r_stall_cnt <= '0;
    else if (w_stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = '0;
`endif

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_pm_clk_sh = {32{r_state == S_HIGH}};
  assign o_pm_din    = r_pm_din;
  assign o_rd_valid  = !w_empty;
  assign o_rd_data   = r_mem[r_rptr[AW-1:0]];

endmodule

// File: tb/tb_pmc_shift_sequencer.sv
// Randomized scoreboard bench for pmc_shift_sequencer; a small matrix model feeds dout per shift pulse.
module tb_pmc_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, start = 1'b0, abort = 1'b0, rd_ready = 1'b0;
  logic [15:0] bit_count = '0;
  logic [7:0]  clk_div = '0;
  logic [31:0] din_word = '0, dout_a = '0, dout_b = '0;
  logic        busy, done, rd_valid;
  logic [31:0] pm_clk_sh, pm_din;
  logic [63:0] rd_data;
  logic [15:0] stall_cnt;

  pmc_shift_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_bit_count(bit_count), .i_clk_div(clk_div), .i_din_word(din_word),
    .o_busy(busy), .o_done(done), .o_pm_clk_sh(pm_clk_sh), .o_pm_din(pm_din),
    .i_pm_dout_a(dout_a), .i_pm_dout_b(dout_b),
    .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data),
    .o_stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [63:0] sb_q[$];
  logic [63:0] cur_words[$];
  int pulse_idx = 0;

  int done_k, n_done, highs, end_k, sh_bad, din_bad, win_hi, pidx_win;
  logic [15:0] st_a, st_b;
  logic [31:0] last_din;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // mode 0: rd_ready=1, mode 1: random rd_ready, mode 2: rd_ready=0 until release_at
  task automatic run_shift(input int n, input int d, input int mode,
                           input int abort_at, input int restart_at, input int release_at);
    logic [31:0] din;
    din = $urandom;
    last_din = din;
    cur_words.delete();
    for (int i = 0; i < n; i++) cur_words.push_back({$urandom, $urandom});
    if (abort_at == 0) begin
      foreach (cur_words[i]) sb_q.push_back(cur_words[i]);
    end else if (n > 0) begin
      sb_q.push_back(cur_words[0]);
    end
    @(posedge clk); #1;
    start = 1'b1; bit_count = 16'(n); clk_div = 8'(d); din_word = din;
    pulse_idx = 0;
    rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge clk); #1;
    start = 1'b0; bit_count = 16'($urandom); clk_div = 8'($urandom); din_word = $urandom;
    done_k = 0; n_done = 0; highs = 0; end_k = 0; sh_bad = 0; din_bad = 0; win_hi = 0;
    pidx_win = 0; st_a = '0; st_b = '0;
    for (int k = 1; k <= 1500; k++) begin
      abort = (k == abort_at);
      start = (k == restart_at);
      if (k == restart_at) bit_count = 16'd7;
      rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (k >= release_at);
      @(negedge clk);
      if (done) begin n_done++; if (done_k == 0) done_k = k; end
      if (pm_clk_sh[0]) highs++;
      if (pm_clk_sh != '0 && pm_clk_sh != '1) sh_bad++;
      if (n > 0 && busy && pm_din != din) din_bad++;
      if (k >= release_at - 6 && k < release_at && pm_clk_sh[0]) win_hi++;
      if (k == release_at - 6) st_a = stall_cnt;
      if (k == release_at - 1) begin st_b = stall_cnt; pidx_win = pulse_idx; end
      if (!busy) begin end_k = k; break; end
      @(posedge clk); #1;
    end
    abort = 1'b0; start = 1'b0;
    chk("shift_terminates", end_k != 0, 1);
    chk("clk_sh_bits_equal", sh_bad, 0);
    if (n > 0) begin
      chk("pm_din_during_busy", din_bad, 0);
      chk("pm_din_held_after", pm_din, din);
    end
  endtask

  task automatic check_normal(input int n, input int d, input int exact);
    int base;
    base = (n == 0) ? 1 : 2 + 2 * (d + 1) * n;
    if (exact != 0) chk("done_cycle", done_k, base);
    else            chk("done_not_early", done_k >= base, 1);
    chk("done_pulses", n_done, 1);
    chk("busy_drop_after_done", end_k, done_k + 1);
    chk("clk_sh_high_cycles", highs, (d + 1) * n);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    rd_ready = 1'b1;
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("fifo_drained", sb_q.size(), 0);
    chk("rd_valid_after_drain", rd_valid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_clk_sh"}, pm_clk_sh, 0);
    chk({tag, "_pm_din"}, pm_din, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_stall_cnt"}, stall_cnt, 0);
  endtask

  initial begin
    int d;
    fork
      forever begin
        @(negedge clk);
        if (rd_valid && rd_ready) begin
          if (sb_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL sb_extra_word: got %0h expected no word", rd_data);
          end else begin
            chk("sb_word", rd_data, sb_q.pop_front());
          end
        end
      end
      forever begin
        @(posedge pm_clk_sh[0]);
        pulse_idx++;
        if (pulse_idx <= cur_words.size()) {dout_b, dout_a} = cur_words[pulse_idx-1];
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // 3 pulses, single-cycle half period
    run_shift(3, 0, 0, 0, 0, 0);
    check_normal(3, 0, 1);
    // 2 pulses, 4-cycle half period
    run_shift(2, 3, 0, 0, 0, 0);
    check_normal(2, 3, 1);
    drain();

    // Backpressure: FIFO fills after 4 words, 5th capture waits for the consumer
    d = $urandom_range(0, 2);
    run_shift(6, d, 2, 0, 0, 2 + 10 * (d + 1) + 20);
    chk("stall_done_cycle", done_k, 2 + 12 * (d + 1) + 21);
    chk("stall_clk_sh_high_cycles", highs, 6 * (d + 1));
    chk("stall_no_pulse_in_hold", win_hi, 0);
    chk("stall_pulses_before_hold", pidx_win, 5);
`ifdef PMC_SEQ_STALL_STATS_EN
    chk("stall_cnt_early", st_a, 15);
    chk("stall_cnt_late", st_b, 20);
`else
    chk("stall_cnt_off", st_b, 0);
`endif
    drain();

    // Zero-length shift leaves the FIFO untouched
    run_shift(2, 1, 2, 0, 0, 100000);
    check_normal(2, 1, 1);
    chk("stall_cnt_cleared", stall_cnt, 0);
    run_shift(0, 2, 2, 0, 0, 100000);
    check_normal(0, 2, 1);
    chk("zero_rd_valid", rd_valid, 1);
    chk("zero_fifo_head", rd_data, sb_q[0]);
    drain();

    // Abort in the first cycle of the second HIGH phase
    d = $urandom_range(0, 3);
    run_shift(5, d, 0, 2 + 2 * (d + 1), 0, 0);
    chk("abort_no_done", n_done, 0);
    chk("abort_busy_drop", end_k, 2 + 2 * (d + 1) + 1);
    chk("abort_clk_sh_low", pm_clk_sh, 0);
    chk("abort_high_cycles", highs, d + 2);
    drain();

    // Restart while busy is ignored
    run_shift(2, 1, 0, 0, 4, 0);
    check_normal(2, 1, 1);
    repeat (3) @(negedge clk);
    chk("restart_no_second_shift", busy, 0);
    drain();

    for (int i = 0; i < 10; i++) begin
      int n, dd;
      n  = $urandom_range(1, 6);
      dd = $urandom_range(0, 3);
      run_shift(n, dd, i % 2, 0, 0, 0);
      check_normal(n, dd, (i % 2 == 0) ? 1 : 0);
      drain();
    end

    // Reset mid-shift with words already captured
    cur_words.delete();
    for (int i = 0; i < 3; i++) cur_words.push_back({$urandom, $urandom});
    @(posedge clk); #1;
    rd_ready = 1'b0; start = 1'b1; bit_count = 16'd3; clk_div = 8'd0; din_word = $urandom;
    pulse_idx = 0;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_reset_rd_valid", rd_valid, 1);
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    sb_q.delete();
    check_all_zero("midreset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
